// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling geometry and the vote helper.
// Imported by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;

   localparam logic [3:0] VOTE_S0 = 4'd7;
   localparam logic [3:0] VOTE_S1 = 4'd8;
   localparam logic [3:0] VOTE_S2 = 4'd9;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle pulse every CLKS_PER_TICK clocks while enabled.
// The counter sits at zero whenever the enable is low, so every frame starts phase-aligned.
module uart_tick_gen #(
   parameter int CLKS_PER_TICK = 326
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iEn,
   output logic oTick
);

   localparam int            CW   = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (iEn && (cnt_q != LAST))
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign oTick = iEn && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampling 8N1 UART receiver with 3-sample majority vote,
// valid/ack output handshake, framing-error pulse and sticky overrun flag.
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int CLKS_PER_TICK = 326
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iRx,
   input  logic       iAck,
   output logic [7:0] oData,
   output logic       oValid,
   output logic       oFrameErr,
   output logic       oOverrun,
   output logic       oBusy
);

   uart_state_e state_q, state_d;
   logic       rx_meta_q, rx_s_q;
   logic [3:0] samp_q, samp_d;
   logic [2:0] bit_q, bit_d;
   logic [1:0] vote_q, vote_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       ferr_q, ferr_d;
   logic       ovr_q, ovr_d;
   logic       tick, decide, wrap, bit_val;

   uart_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
      .iClk  (iClk),
      .iRst  (iRst),
      .iEn   (state_q != IDLE),
      .oTick (tick)
   );

   assign decide  = tick && (samp_q == VOTE_S2);
   assign wrap    = tick && (samp_q == 4'(OVERSAMPLE - 1));
   assign bit_val = majority3(vote_q[0], vote_q[1], rx_s_q);

   always_comb begin
      state_d = state_q;
      samp_d  = samp_q;
      bit_d   = bit_q;
      vote_d  = vote_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = ovr_q;

      if (valid_q && iAck) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      if (tick) samp_d = samp_q + 4'd1;
      if (tick && (samp_q == VOTE_S0)) vote_d[0] = rx_s_q;
      if (tick && (samp_q == VOTE_S1)) vote_d[1] = rx_s_q;

      case (state_q)
         IDLE: begin
            samp_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (decide && bit_val) begin
               state_d = IDLE;
            end else if (wrap) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (decide) shreg_d = {bit_val, shreg_q[7:1]};
            if (wrap) begin
               if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
               else                            bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (decide) begin
               state_d = IDLE;
               if (bit_val) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  if (valid_q && !iAck) ovr_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= IDLE;
         samp_q    <= '0;
         bit_q     <= '0;
         vote_q    <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         rx_meta_q <= iRx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         samp_q    <= samp_d;
         bit_q     <= bit_d;
         vote_q    <= vote_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign oData     = data_q;
   assign oValid    = valid_q;
   assign oFrameErr = ferr_q;
   assign oOverrun  = ovr_q;
   assign oBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 with CLKS_PER_TICK=4 (64 clocks per bit):
// a frame table plus hand-written glitch, simultaneous-ack and mid-frame reset sequences.
module tb_uart_rx_os16;

   localparam int CPT     = 4;
   localparam int BIT_CYC = 16 * CPT;
   localparam int LAT     = 619;   // iRx start edge drive -> oValid rise (2 sync + 617)

   logic       iClk, iRst, iRx, iAck;
   logic [7:0] oData;
   logic       oValid, oFrameErr, oOverrun, oBusy;

   uart_rx_os16 #(.CLKS_PER_TICK(CPT)) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iRx       (iRx),
      .iAck      (iAck),
      .oData     (oData),
      .oValid    (oValid),
      .oFrameErr (oFrameErr),
      .oOverrun  (oOverrun),
      .oBusy     (oBusy)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   int   last_rise_cyc = -1;
   int   ferr_pulses   = 0;
   logic valid_prev    = 1'b0;
   always @(negedge iClk) begin
      valid_prev <= oValid;
      if (oValid && !valid_prev) last_rise_cyc <= cyc;
      if (oFrameErr)             ferr_pulses   <= ferr_pulses + 1;
   end

   int tests  = 0;
   int failed = 0;
   int start_cyc;
   int f0;

   typedef struct {
      logic [7:0] tx;
      logic       stop;
      logic       ack_after;
      logic [7:0] exp_data;
      logic       exp_valid;
      int         exp_ferr;
      logic       exp_ovr;
      int         exp_lat;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge iClk);
      #1;
   endtask

   // Called 1 time unit after a rising edge; returns in the same phase.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      iRx = 1'b0;
      start_cyc = cyc;
      wait_cyc(BIT_CYC);
      for (int i = 0; i < 8; i++) begin
         iRx = b[i];
         wait_cyc(BIT_CYC);
      end
      iRx = stop;
      wait_cyc(BIT_CYC);
      iRx = 1'b1;
      wait_cyc(100);
   endtask

   task automatic pulse_ack();
      iAck = 1'b1;
      wait_cyc(1);
      iAck = 1'b0;
   endtask

   initial begin
      vecs[0] = '{tx: 8'hA5, stop: 1'b1, ack_after: 1'b1, exp_data: 8'hA5, exp_valid: 1'b1,
                  exp_ferr: 0, exp_ovr: 1'b0, exp_lat: LAT};
      vecs[1] = '{tx: 8'h3C, stop: 1'b0, ack_after: 1'b0, exp_data: 8'hA5, exp_valid: 1'b0,
                  exp_ferr: 1, exp_ovr: 1'b0, exp_lat: 0};
      vecs[2] = '{tx: 8'h11, stop: 1'b1, ack_after: 1'b0, exp_data: 8'h11, exp_valid: 1'b1,
                  exp_ferr: 0, exp_ovr: 1'b0, exp_lat: LAT};
      vecs[3] = '{tx: 8'h22, stop: 1'b1, ack_after: 1'b1, exp_data: 8'h22, exp_valid: 1'b1,
                  exp_ferr: 0, exp_ovr: 1'b1, exp_lat: 0};

      iRst = 1'b1; iRx = 1'b1; iAck = 1'b0;
      wait_cyc(3);
      check("rst_data",  oData,     0);
      check("rst_valid", oValid,    0);
      check("rst_ferr",  oFrameErr, 0);
      check("rst_ovr",   oOverrun,  0);
      check("rst_busy",  oBusy,     0);
      iRst = 1'b0;
      wait_cyc(3);

      for (int i = 0; i < 4; i++) begin
         f0 = ferr_pulses;
         send_frame(vecs[i].tx, vecs[i].stop);
         check($sformatf("v%0d_data", i),  oData,             vecs[i].exp_data);
         check($sformatf("v%0d_valid", i), oValid,            vecs[i].exp_valid);
         check($sformatf("v%0d_ferr", i),  ferr_pulses - f0,  vecs[i].exp_ferr);
         check($sformatf("v%0d_ovr", i),   oOverrun,          vecs[i].exp_ovr);
         check($sformatf("v%0d_busy", i),  oBusy,             0);
         if (vecs[i].exp_lat != 0)
            check($sformatf("v%0d_latency", i), last_rise_cyc - start_cyc, vecs[i].exp_lat);
         if (vecs[i].ack_after) begin
            pulse_ack();
            check($sformatf("v%0d_ack_valid", i), oValid,   0);
            check($sformatf("v%0d_ack_ovr", i),   oOverrun, 0);
         end
      end

      // Glitch: 8-clock low pulse must be rejected by the start vote.
      f0 = ferr_pulses;
      iRx = 1'b0;
      wait_cyc(8);
      iRx = 1'b1;
      check("glitch_busy_hi", oBusy, 1);
      wait_cyc(60);
      check("glitch_busy_lo", oBusy,            0);
      check("glitch_valid",   oValid,           0);
      check("glitch_ferr",    ferr_pulses - f0, 0);
      check("glitch_data",    oData,            8'h22);
      wait_cyc(50);

      // Simultaneous ack with the loading stop decision.
      send_frame(8'h11, 1'b1);
      check("sim_pre_valid", oValid, 1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            wait_cyc(LAT - 1);
            iAck = 1'b1;
            wait_cyc(1);
            iAck = 1'b0;
         end
      join
      check("sim_valid", oValid,   1);
      check("sim_data",  oData,    8'h22);
      check("sim_ovr",   oOverrun, 0);

      // Reset during data bit 4 of 0xFF.
      fork
         send_frame(8'hFF, 1'b1);
         begin
            wait_cyc(5 * BIT_CYC + 30);
            check("mid_busy_before", oBusy, 1);
            iRst = 1'b1;
            #1;
            check("mid_rst_data",  oData,     0);
            check("mid_rst_valid", oValid,    0);
            check("mid_rst_ferr",  oFrameErr, 0);
            check("mid_rst_ovr",   oOverrun,  0);
            check("mid_rst_busy",  oBusy,     0);
            wait_cyc(1);
            iRst = 1'b0;
         end
      join
      check("post_rst_valid", oValid, 0);
      f0 = ferr_pulses;
      send_frame(8'h7E, 1'b1);
      check("r7e_data",    oData,                     8'h7E);
      check("r7e_valid",   oValid,                    1);
      check("r7e_ferr",    ferr_pulses - f0,          0);
      check("r7e_ovr",     oOverrun,                  0);
      check("r7e_latency", last_rise_cyc - start_cyc, LAT);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART receiver. It converts an asynchronous 8N1 serial line into parallel bytes with a valid/acknowledge handshake, and flags framing errors and overruns. It is the serial-in counterpart of the transmitter. Its parallel output feeds the binary-to-BCD splitter and display chain, and it replaces the naive single-sample receive path.

## Interface
Parameters:
- CLKS_PER_TICK, 326: iClk cycles per oversample tick. 326 gives 50 MHz / (9600 × 16). Minimum is 2.

Ports:
- iClk  in  1  system clock; all state updates on the rising edge
- iRst  in  1  asynchronous, active-high reset
- iRx  in  1  serial line; idle high; asynchronous to iClk
- iAck  in  1  consumer acknowledge; sampled only while oValid=1
- oData  out  8  last good received byte; reset 8'h00
- oValid  out  1  oData holds an unacknowledged byte; reset 0
- oFrameErr  out  1  one-cycle pulse when a stop bit is sampled low; reset 0
- oOverrun  out  1  sticky flag: a byte was overwritten before acknowledge; reset 0
- oBusy  out  1  high in every state except IDLE; reset 0

## Operation
- **Input synchronizer:** iRx passes through 2 flip-flops (both reset to 1) to give rx_s. All logic uses rx_s only.
- **Tick generator:**
  - Counter runs 0..CLKS_PER_TICK-1 and emits a one-cycle tick at terminal count.
  - The counter is held at 0 in IDLE and starts counting on the IDLE→START transition.
- **Sample counter:** 4 bits, 0..15 per bit period, advanced on each tick, wraps 15→0 at the bit boundary.
- **Majority vote:** rx_s is captured on ticks with sample index 7, 8 and 9. The bit value is the majority of the three, decided on sample 9.
- **FSM states:**
  - IDLE: on rx_s==0, go to START and clear the tick and sample counters.
  - START: at the sample-9 decision, vote 1 → IDLE (false start, no flags); vote 0 → continue. On wrap 15→0, go to DATA with bit index 0.
  - DATA: the vote is shifted into the shift register, LSB first. After 8 bit periods (wrap on bit index 7), go to STOP.
  - STOP: at the sample-9 decision, go directly to IDLE without waiting for sample 15, so the next start edge can be caught early.
    - Vote 1: load oData with the shift register and set oValid.
    - Vote 0: pulse oFrameErr; oData, oValid and the shift register result are discarded/unchanged.
- **Handshake:**
  - iAck=1 while oValid=1 clears oValid, and clears oOverrun, on the next edge.
  - iAck while oValid=0 is ignored.
- **Overrun:**
  - A good stop arrives while oValid=1 and iAck=0 in that cycle: oData is overwritten, oValid stays 1, oOverrun is set.
  - A good stop arrives in the same cycle as iAck: oData takes the new byte, oValid stays 1, oOverrun is not set.
- **Reset:** iRst at any time (including mid-byte) forces IDLE, clears both counters and the shift register, and sets every output to its reset value immediately.

## Timing
- T0 is the edge where rx_s first reads 0. This is 2 cycles after iRx falls, ±1 cycle of synchronizer uncertainty.
- The tick with overall index k (0-based, counted from T0) pulses at cycle T0 + (k+1)·CLKS_PER_TICK.
- Start decision is at tick index 9. Data bit n (0..7) is decided at tick index 16·(n+1)+9. Stop decision is at tick index 153.
- oValid rises, or oFrameErr pulses, at T0 + 154·CLKS_PER_TICK + 1. The FSM is in IDLE on that same edge.
- oBusy is high from T0+1 until the edge on which the FSM returns to IDLE.
- Baud mismatch tolerance is ±3% by construction: the sample point is mid-bit and resync happens at every start edge.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - OVERSAMPLE=16;
  - the vote sample indices 7, 8, 9;
  - DATA_BITS=8.
  The transmitter imports the same package.
- One sub-module, uart_tick_gen, parameterised by CLKS_PER_TICK, with inputs iClk, iRst and an enable, and output tick.
- FSM, vote, shift register and handshake logic live in uart_rx_os16.

## Test plan
All scenarios use CLKS_PER_TICK=4, so one bit is 64 clocks.
- **Clean byte:** send 0xA5 in 8N1 → oValid rises at T0+617 with oData=8'hA5; oFrameErr=0, oOverrun=0.
- **Glitch:** drive iRx low for 8 clocks, then high → FSM returns to IDLE after the start vote; oValid and oFrameErr stay 0; oBusy falls.
- **Framing error:** send 0x3C with the stop bit held low → oFrameErr high for exactly 1 cycle; oValid stays 0; oData keeps its previous value.
- **Overrun:** send 0x11 then 0x22 without iAck → oData=8'h22, oValid=1, oOverrun=1. A single iAck pulse then clears oValid and oOverrun on the next edge.
- **Simultaneous event:** assert iAck on the exact cycle 0x22's stop decision loads → oValid stays 1, oData=8'h22, oOverrun=0.
- **Reset mid-frame:** pulse iRst during data bit 4 of 0xFF → all outputs return to reset values at once; a following 0x7E is received correctly with no error flags.
